serial_subtractor: RTL and testbench

Bit-serial subtractor computing Diff = A - B - Bin over WIDTH clock cycles, LSB first, with a borrow flop carried between bits. It is the inverse-operation counterpart of the combinational 8-bit ripple-carry adder and trades latency for a single 1-bit cell. Operands come in and results go out over valid/ready handshakes, so it can sit between register stages in the TT datapath.

---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
//   state_e          : controller states (idle, shifting, result held)
//   DefaultWidth     : default operand/result width
//   cnt_width()      : width of the bit counter for a given operand width
//   DefaultCntWidth  : counter width for the default operand width
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow-in
//   d    : difference bit
//   bout : borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin over WIDTH cycles, LSB first.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only when idle)
//   A, B, Bin            : minuend, subtrahend, borrow-in
//   out_valid/out_ready  : result handshake (result held until accepted)
//   Diff, Bout, Ovf      : difference, unsigned borrow-out, signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [CntW-1:0]  r_cnt;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Difference bits enter at the MSB so the LSB-first result ends up aligned.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a_sr     <= A;
            r_b_sr     <= B;
            r_a_msb    <= A[WIDTH-1];
            r_b_msb    <= B[WIDTH-1];
            r_borrow   <= Bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StShift;
          end
        end
        StShift: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          if (r_cnt == CntLast) begin
            // Capture the finished result directly from this cycle's cell output.
            r_diff      <= w_res_next;
            r_bout      <= w_bout;
            r_ovf       <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign Diff      = r_diff;
  assign Bout      = r_bout;
  assign Ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int ua, ub, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    s  = sa - sb - int'(bin);
    e.d = W'((ua - ub - int'(bin)) & 255);
    e.b = (ua < ub + int'(bin));
    e.o = (s < -128) || (s > 127);
    return e;
  endfunction

  // Monitor: compare whenever a result is transferred.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("Diff", 32'(Diff), 32'(e.d));
        check("Bout", 32'(Bout), 32'(e.b));
        check("Ovf", 32'(Ovf), 32'(e.o));
      end
    end
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_in_ready();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one operation; optionally measure cycles from accept edge to out_valid.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input bit meas_lat);
    int lat;
    wait_in_ready();
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    sb_q.push_back(model(a, b, bin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom);
    if (meas_lat) begin
      lat = -1;
      for (int i = 1; i <= 50; i++) begin
        if (out_valid) begin
          lat = i - 1;
          break;
        end
        @(posedge clk);
        #1;
      end
      check("latency", 32'(lat), 32'd8);
    end
  endtask

  initial begin
    exp_t bp;
    bit   seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Diff", 32'(Diff), 32'd0);
    check("rst_Bout", 32'(Bout), 32'd0);
    check("rst_Ovf", 32'(Ovf), 32'd0);

    // Directed cases.
    send(8'h05, 8'h03, 1'b0, 1'b1);
    send(8'h03, 8'h05, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b0, 1'b0);
    send(8'h7F, 8'hFF, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b1, 1'b0);
    send(8'hA5, 8'hA5, 1'b1, 1'b1);
    send(8'h80, 8'h00, 1'b1, 1'b0);

    // Backpressure with a new transaction driven throughout.
    wait_in_ready();
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h5A, 8'h33, 1'b1, 1'b0);
    bp = model(8'h5A, 8'h33, 1'b1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("bp_out_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      A = W'($urandom);
      B = W'($urandom);
      Bin = 1'($urandom);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_Diff", 32'(Diff), 32'(bp.d));
      check("bp_Bout", 32'(Bout), 32'(bp.b));
      check("bp_Ovf", 32'(Ovf), 32'(bp.o));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    send(8'h10, 8'h20, 1'b0, 1'b1);

    // Reset in the 4th SHIFT cycle aborts the operation with no output.
    wait_in_ready();
    A = 8'h44;
    B = 8'h11;
    Bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_Diff", 32'(Diff), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_output", 32'(out_valid), 32'd0);

    // Random operations with random backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("drain_timeout", 32'(sb_q.size()), 32'd0);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
